// File: rtl/sid_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : sid_i2s_tx
// Purpose  : I2S serial transmitter for 24-bit audio, 64 bclk per frame.
//            Define SID_I2S_STEREO_EN for a separate right channel.
// Revision : 1.0  initial release
// ============================================================================
module sid_i2s_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [23:0] audio_i,
`ifdef SID_I2S_STEREO_EN
  input  logic signed [23:0] audio_r_i,
`endif
  input  logic               valid_i,
  input  logic               clear_i,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sdata,
  output logic               frame_o,
  output logic               overrun_o,
  output logic               underrun_o
);

  localparam logic [7:0] c_div_max  = 8'(CLK_DIV - 1);
  localparam logic [0:0] c_st_mute  = 1'b0;
  localparam logic [0:0] c_st_run   = 1'b1;

  logic [7:0]  r_div_cnt;
  logic [5:0]  r_bit_cnt;
  logic [23:0] r_hold_l;
  logic [23:0] r_shift_l;
  logic        r_new_flag;
  logic [0:0]  r_state;

  logic        w_div_wrap;
  logic        w_fall;
  logic        w_load;
  logic [5:0]  w_bit_cnt_next;
  logic        w_slot;
  logic [4:0]  w_pos;
  logic [4:0]  w_idx;
  logic [23:0] w_word;
  logic [23:0] w_word_r;
  logic        w_bit;
  logic        w_lr_next;

  assign w_div_wrap     = (r_div_cnt == c_div_max);
  assign w_fall         = w_div_wrap & i2s_bclk;
  assign w_bit_cnt_next = r_bit_cnt + 6'd1;
  assign w_load         = w_fall & (w_bit_cnt_next == 6'd63);

  // Bit 5 of (bit_cnt_next + 1) mod 64: high for next counts 31..62.
  assign w_lr_next = (w_bit_cnt_next >= 6'd31) & (w_bit_cnt_next != 6'd63);

  assign w_slot = w_bit_cnt_next[5];
  assign w_pos  = w_bit_cnt_next[4:0];
  assign w_idx  = 5'd23 - w_pos;
  assign w_word = w_slot ? w_word_r : r_shift_l;
  assign w_bit  = (w_pos < 5'd24) ? w_word[w_idx] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= 8'd0;
      i2s_bclk  <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= 8'd0;
      i2s_bclk  <= ~i2s_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 6'd62;
      i2s_lrclk <= 1'b1;
      i2s_sdata <= 1'b0;
      frame_o   <= 1'b0;
    end else begin
      frame_o <= w_load;
      if (w_fall) begin
        r_bit_cnt <= w_bit_cnt_next;
        i2s_lrclk <= w_lr_next;
        i2s_sdata <= (r_state == c_st_run) & w_bit;
      end
    end
  end

  // A valid in the load cycle writes hold after the old hold is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_l   <= 24'd0;
      r_shift_l  <= 24'd0;
      r_new_flag <= 1'b0;
      r_state    <= c_st_mute;
    end else begin
      if (valid_i) begin
        r_hold_l <= audio_i;
      end
      if (w_load && r_new_flag) begin
        r_shift_l <= r_hold_l;
        r_state   <= c_st_run;
      end
      if (valid_i) begin
        r_new_flag <= 1'b1;
      end else if (w_load) begin
        r_new_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (valid_i && r_new_flag && !w_load) begin
        overrun_o <= 1'b1;
      end else if (clear_i) begin
        overrun_o <= 1'b0;
      end
      if (w_load && !r_new_flag && (r_state == c_st_run)) begin
        underrun_o <= 1'b1;
      end else if (clear_i) begin
        underrun_o <= 1'b0;
      end
    end
  end

`ifdef SID_I2S_STEREO_EN
  logic [23:0] r_hold_r;
  logic [23:0] r_shift_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_r  <= 24'd0;
      r_shift_r <= 24'd0;
    end else begin
      if (valid_i) begin
        r_hold_r <= audio_r_i;
      end
      if (w_load && r_new_flag) begin
        r_shift_r <= r_hold_r;
      end
    end
  end

  assign w_word_r = r_shift_r;
`else
  assign w_word_r = r_shift_l;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sid_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sid_i2s_tx
// Purpose  : Self-checking bench for sid_i2s_tx against a frame-window model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sid_i2s_tx;

  localparam int CLK_DIV = 2;
  localparam int BIT     = 2 * CLK_DIV;
  localparam int FRAME   = 64 * BIT;
  localparam int FIRST   = BIT;
`ifdef SID_I2S_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic signed [23:0] audio_i;
`ifdef SID_I2S_STEREO_EN
  logic signed [23:0] audio_r;
`endif
  logic               valid_i;
  logic               clear_i;
  logic               i2s_bclk;
  logic               i2s_lrclk;
  logic               i2s_sdata;
  logic               frame_o;
  logic               overrun_o;
  logic               underrun_o;

  sid_i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_i    (audio_i),
`ifdef SID_I2S_STEREO_EN
    .audio_r_i  (audio_r),
`endif
    .valid_i    (valid_i),
    .clear_i    (clear_i),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata),
    .frame_o    (frame_o),
    .overrun_o  (overrun_o),
    .underrun_o (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; load edges sit at FIRST + k*FRAME.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int          total = 0;
  int          bad   = 0;
  int          v_edge[$];
  logic [23:0] v_dl[$];
  logic [23:0] v_dr[$];
  int          clr_edge = 0;

  // Each load takes the last sample seen in the window since the previous
  // load (a valid on a load edge belongs to the next window).
  function automatic void model(input int upto, output logic [23:0] wl,
                                output logic [23:0] wr, output bit ovr,
                                output bit und);
    bit run;
    int cnt;
    int lo;
    logic [23:0] dl, dr;
    run = 0; wl = '0; wr = '0; ovr = 0; und = 0;
    for (int ld = FIRST; ld <= upto + FRAME; ld += FRAME) begin
      lo  = (ld == FIRST) ? 0 : ld - FRAME;
      cnt = 0; dl = '0; dr = '0;
      for (int i = 0; i < v_edge.size(); i++) begin
        if (v_edge[i] >= lo && v_edge[i] < ld && v_edge[i] <= upto) begin
          cnt++;
          dl = v_dl[i];
          dr = v_dr[i];
          if (cnt >= 2 && v_edge[i] >= clr_edge) ovr = 1;
        end
      end
      if (ld <= upto) begin
        if (cnt > 0) begin
          wl = dl; wr = dr; run = 1;
        end else if (run && ld >= clr_edge) begin
          und = 1;
        end
      end
    end
  endfunction

  task automatic goto(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      total++; bad++;
      $display("FAIL goto_timeout: at cycle %0d, wanted cycle %0d", cyc, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(negedge clk);
    v_edge.delete(); v_dl.delete(); v_dr.delete();
    clr_edge = 0;
    rst_n = 1'b1;
  endtask

  task automatic drive_valid(input int e, input logic [23:0] l, input logic [23:0] r);
    goto(e - 1);
    audio_i = l;
`ifdef SID_I2S_STEREO_EN
    audio_r = r;
`endif
    valid_i = 1'b1;
    v_edge.push_back(e);
    v_dl.push_back(l);
    v_dr.push_back(STEREO ? r : l);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i  = 1'b1;
    clr_edge = cyc + 1;
    @(negedge clk);
    clear_i  = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    logic [23:0] el, er;
    bit ovr, und;
    model(cyc, el, er, ovr, und);
    total++;
    if (overrun_o !== ovr) begin
      bad++; $display("FAIL %s overrun: got %b want %b", tag, overrun_o, ovr);
    end
    total++;
    if (underrun_o !== und) begin
      bad++; $display("FAIL %s underrun: got %b want %b", tag, underrun_o, und);
    end
  endtask

  task automatic check_frame(input int ld, input string tag);
    logic [23:0] gl, gr, el, er;
    bit ovr, und;
    int lr_err, pad_err, clk_err, pos, slot;
    gl = '0; gr = '0; lr_err = 0; pad_err = 0; clk_err = 0;
    goto(ld);
    total++;
    if (frame_o !== 1'b1) begin
      bad++; $display("FAIL %s frame_pulse: got %b want 1", tag, frame_o);
    end
    if (i2s_lrclk !== 1'b0) lr_err++;
    goto(ld + 1);
    total++;
    if (frame_o !== 1'b0) begin
      bad++; $display("FAIL %s frame_width: got %b want 0", tag, frame_o);
    end
    for (int m = 1; m < 64; m++) begin
      goto(ld + BIT * m - CLK_DIV);
      if (i2s_bclk !== 1'b1) clk_err++;
      goto(ld + BIT * m);
      if (i2s_bclk !== 1'b0) clk_err++;
      if (i2s_lrclk !== ((m >= 32) ? 1'b1 : 1'b0)) lr_err++;
      pos  = (m - 1) % 32;
      slot = (m - 1) / 32;
      if (pos < 24) begin
        if (slot == 0) gl[23 - pos] = i2s_sdata;
        else           gr[23 - pos] = i2s_sdata;
      end else if (i2s_sdata !== 1'b0) begin
        pad_err++;
      end
    end
    model(ld, el, er, ovr, und);
    total++;
    if (gl !== el) begin
      bad++; $display("FAIL %s left_word: got %h want %h", tag, gl, el);
    end
    total++;
    if (gr !== er) begin
      bad++; $display("FAIL %s right_word: got %h want %h", tag, gr, er);
    end
    total++;
    if (lr_err != 0) begin
      bad++; $display("FAIL %s lrclk: got %0d wrong samples want 0", tag, lr_err);
    end
    total++;
    if (pad_err != 0) begin
      bad++; $display("FAIL %s pad_bits: got %0d nonzero want 0", tag, pad_err);
    end
    total++;
    if (clk_err != 0) begin
      bad++; $display("FAIL %s bclk: got %0d wrong samples want 0", tag, clk_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (i2s_bclk   !== 1'b0) begin bad++; $display("FAIL rst_bclk: got %b want 0", i2s_bclk); end
    total++; if (i2s_lrclk  !== 1'b1) begin bad++; $display("FAIL rst_lrclk: got %b want 1", i2s_lrclk); end
    total++; if (i2s_sdata  !== 1'b0) begin bad++; $display("FAIL rst_sdata: got %b want 0", i2s_sdata); end
    total++; if (frame_o    !== 1'b0) begin bad++; $display("FAIL rst_frame: got %b want 0", frame_o); end
    total++; if (overrun_o  !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun_o); end
    total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", underrun_o); end
    v_edge.delete(); v_dl.delete(); v_dr.delete();
    clr_edge = 0;
    rst_n = 1'b1;
    goto(CLK_DIV);
    total++; if (i2s_bclk !== 1'b1) begin bad++; $display("FAIL rst_first_rise: got %b want 1", i2s_bclk); end
    total++; if (i2s_lrclk !== 1'b1) begin bad++; $display("FAIL rst_lr_hold: got %b want 1", i2s_lrclk); end
    goto(FIRST - 1);
    total++; if (frame_o !== 1'b0) begin bad++; $display("FAIL rst_early_frame: got %b want 0", frame_o); end
    check_frame(FIRST, "mute_frame");
    check_flags("mute_frame");
  endtask

  task automatic test_first_frame();
    do_reset();
    drive_valid(2, 24'h800001, 24'h800001);
    check_frame(FIRST, "first");
    check_flags("first");
  endtask

  task automatic test_underrun();
    do_reset();
    drive_valid(2, 24'h000ABC, 24'h000ABC);
    check_frame(FIRST, "under_a");
    check_frame(FIRST + FRAME, "under_b");
    check_flags("under_set");
    pulse_clear();
    check_flags("under_clr");
  endtask

  task automatic test_overrun();
    do_reset();
    drive_valid(50, 24'h123456, 24'h0F0F0F);
    drive_valid(120, 24'h654321, 24'h0A0B0C);
    check_flags("over_set");
    check_frame(FIRST + FRAME, "over_frame");
    check_flags("over_frame");
    pulse_clear();
    check_flags("over_clr");
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_valid(100, 24'h222222, 24'h333333);
    fork
      check_frame(FIRST + FRAME, "coinc_a");
      drive_valid(FIRST + FRAME, 24'h111111, 24'h444444);
    join
    check_frame(FIRST + 2 * FRAME, "coinc_b");
    check_flags("coinc");
  endtask

  task automatic test_random();
    int ld, n, e1, e2;
    do_reset();
    if ($urandom_range(0, 1) == 1)
      drive_valid(2, 24'($urandom()), 24'($urandom()));
    for (int f = 0; f < 6; f++) begin
      ld = FIRST + f * FRAME;
      n  = $urandom_range(0, 2);
      e1 = ld + $urandom_range(0, 120);
      e2 = e1 + $urandom_range(1, 130);
      fork
        check_frame(ld, "rnd");
        begin
          if (n >= 1) drive_valid(e1, 24'($urandom()), 24'($urandom()));
          if (n >= 2) drive_valid(e2, 24'($urandom()), 24'($urandom()));
        end
      join
      check_flags("rnd");
      if (f == 3) begin
        pulse_clear();
        check_flags("rnd_clr");
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive_valid(2, 24'hFFFFFF, 24'hFFFFFF);
    goto(FIRST + BIT * 5 + CLK_DIV);
    total++; if (i2s_sdata !== 1'b1) begin bad++; $display("FAIL mid_pre_sdata: got %b want 1", i2s_sdata); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (i2s_bclk  !== 1'b0) begin bad++; $display("FAIL mid_bclk: got %b want 0", i2s_bclk); end
    total++; if (i2s_lrclk !== 1'b1) begin bad++; $display("FAIL mid_lrclk: got %b want 1", i2s_lrclk); end
    total++; if (i2s_sdata !== 1'b0) begin bad++; $display("FAIL mid_sdata: got %b want 0", i2s_sdata); end
    total++; if (frame_o   !== 1'b0) begin bad++; $display("FAIL mid_frame: got %b want 0", frame_o); end
    @(negedge clk);
    v_edge.delete(); v_dl.delete(); v_dr.delete();
    clr_edge = 0;
    rst_n = 1'b1;
    check_frame(FIRST, "mid_a");
    fork
      check_frame(FIRST + FRAME, "mid_b");
      drive_valid(300, 24'h5A5A5A, 24'hA5A5A5);
    join
    check_flags("mid_b");
    check_frame(FIRST + 2 * FRAME, "mid_c");
  endtask

`ifdef SID_I2S_STEREO_EN
  task automatic test_stereo();
    do_reset();
    drive_valid(2, 24'h7FFFFF, 24'h000001);
    check_frame(FIRST, "stereo");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0; audio_i = '0;
`ifdef SID_I2S_STEREO_EN
    audio_r = '0;
`endif
    test_reset();
    test_first_frame();
    test_underrun();
    test_overrun();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef SID_I2S_STEREO_EN
    test_stereo();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sid_i2s_tx.md
SID_I2S_TX -- requirements
Module: sid_i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving clk cycles per i2s_bclk half-period; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  system clock; all logic in this single domain.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: audio_i  input  24  signed sample (sid::s24_t), left or mono channel.
REQ-005 SHALL have port: audio_r_i  input  24  signed right sample; present only with SID_I2S_STEREO_EN.
REQ-006 SHALL have port: valid_i  input  1  single-cycle strobe qualifying audio inputs.
REQ-007 SHALL have port: clear_i  input  1  clears sticky flags.
REQ-008 SHALL have ports: i2s_bclk, i2s_lrclk, i2s_sdata  output  1 each; lrclk 0 = left slot.
REQ-009 SHALL have ports: frame_o  output  1  one-cycle pulse on shift-register load; overrun_o, underrun_o  output  1  sticky flags.

Function
REQ-010 SHALL run div_cnt 0..CLK_DIV-1; on wrap, i2s_bclk toggles; bclk period = 2*CLK_DIV clk.
REQ-011 SHALL advance bit_cnt (6 bit, wraps 63->0) only in the cycle bclk toggles 1->0 (falling edge); all serial outputs update only then.
REQ-012 SHALL set i2s_lrclk at each falling edge to bit 5 of (bit_cnt_next+1) mod 64, so lrclk leads slot data by one bclk.
REQ-013 SHALL drive i2s_sdata at each falling edge: slot = bit_cnt_next[5], pos = bit_cnt_next[4:0]; pos<24 -> bit (23-pos) of slot's shift word, MSB first; pos 24..31 -> 0.
REQ-014 SHALL capture audio inputs into hold registers on valid_i, latest wins, and set new_flag.
REQ-015 SHALL load shift words from hold registers on the falling edge where bit_cnt_next = 63, pulse frame_o that cycle, clear new_flag.
REQ-016 SHALL set overrun_o when valid_i arrives while new_flag is set and no load occurs that cycle.
REQ-017 SHALL, at load with new_flag clear, retain previous shift words (sample repeat) and set underrun_o.
REQ-018 SHALL, on valid_i coincident with load, load the pre-cycle hold value, write the new sample to hold, leave new_flag set; no overrun.
REQ-019 SHALL implement states MUTE and RUN: MUTE forces sdata 0 and suppresses underrun; MUTE->RUN at first load with new_flag set; RUN has no exit except reset.
REQ-020 SHALL give set priority over clear_i when both coincide.

Reset
REQ-021 SHALL, while rst_n low, immediately force: i2s_bclk 0, i2s_lrclk 1, i2s_sdata 0, frame_o 0, overrun_o 0, underrun_o 0, div_cnt 0, bit_cnt 62, hold/shift 0, new_flag 0, state MUTE.
REQ-022 SHALL produce the first falling edge 2*CLK_DIV cycles after rst_n release, with bit_cnt_next 63 (first load).
REQ-023 SHALL abandon any partial frame on mid-frame reset; no partial sample completes after release.

Configuration
REQ-024 SHALL, with SID_I2S_STEREO_EN defined, provide audio_r_i and transmit it in the right slot.
REQ-025 SHALL, without SID_I2S_STEREO_EN, omit audio_r_i and transmit the left word in both slots.

Verification
REQ-026 CLK_DIV=2, mono, valid_i with 24'h800001 before first falling edge -> frame_o at cycle 4; left slot 1,22x0,1 then 8x0; right slot identical; state RUN.
REQ-027 One sample 24'h000ABC then no valid_i -> next load: underrun_o=1, 24'h000ABC repeated in both slots.
REQ-028 Two valid_i in one frame, 24'h123456 then 24'h654321 -> overrun_o=1; next frame carries 24'h654321; clear_i then clears overrun_o.
REQ-029 valid_i 24'h111111 in load cycle with hold 24'h222222 pending -> current frame 24'h222222, next 24'h111111, overrun_o=0.
REQ-030 rst_n low mid left slot -> same cycle bclk 0, lrclk 1, sdata 0, MUTE; after release sdata stays 0 until a new sample loads.
REQ-031 SID_I2S_STEREO_EN, L=24'h7FFFFF, R=24'h000001 -> left slot 0,23x1; right slot 23x0,1; lrclk toggles one bclk before each MSB.
